// File: rtl/mem_port_arbiter.sv
// Purpose: shares one single-port word memory between instruction fetch (I) and load/store (D).
// Latency: grant to response valid is 2 cycles (accept -> access -> response), one grant per cycle.
// Backpressure: requesters hold their request until granted; D has priority, I is starvation-protected.
//
// Ports:
//   clk, rst                    clock and synchronous active-high reset
//   if_req/if_addr -> if_gnt    I request, accepted combinationally
//   if_valid/if_rdata           I fetch response (valid pulses, data holds)
//   d_req/d_we/d_addr/d_wdata   D request; d_gnt accepts it combinationally
//   d_valid/d_rdata/d_err       D response; d_err flags a misaligned access
//   mem_A/mem_WD/mem_WE/mem_RD  memory port (combinational read, posedge write)
module mem_port_arbiter #(
    parameter int unsigned MAX_CONSEC = 4,
    parameter int unsigned AW         = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic          if_gnt,
    output logic          if_valid,
    output logic [31:0]   if_rdata,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [31:0]   d_wdata,
    output logic          d_gnt,
    output logic          d_valid,
    output logic [31:0]   d_rdata,
    output logic          d_err,
    output logic [AW-1:0] mem_A,
    output logic [31:0]   mem_WD,
    output logic          mem_WE,
    input  logic [31:0]   mem_RD
);

    localparam logic [3:0] MAX_C = 4'(MAX_CONSEC);

    // Starvation counter: consecutive D grants taken while I was waiting.
    logic [3:0]    cnt_q, cnt_d;

    // Access stage. Address/wdata only load on a grant, so mem_A/mem_WD
    // hold their last value while the stage is empty.
    logic          stg_vld_q;
    logic          stg_own_q;   // 1 = D, 0 = I
    logic          stg_we_q;
    logic          stg_mis_q;   // misaligned D access
    logic [AW-1:0] stg_addr_q;
    logic [31:0]   stg_wd_q;

    // Response stage.
    logic          if_valid_q, d_valid_q, d_err_q;
    logic [31:0]   if_rdata_q, d_rdata_q;

    logic          gnt_i, gnt_d;

    // I wins only when D is idle or when D has used up its consecutive quota.
    always_comb begin
        gnt_d = 1'b0;
        gnt_i = 1'b0;
        cnt_d = cnt_q;
        if (!rst) begin
            gnt_d = d_req && !(if_req && (cnt_q == MAX_C));
            gnt_i = if_req && !gnt_d;
        end
        if (!if_req || gnt_i) begin
            cnt_d = 4'd0;
        end else if (gnt_d) begin
            cnt_d = cnt_q + 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q      <= 4'd0;
            stg_vld_q  <= 1'b0;
            stg_own_q  <= 1'b0;
            stg_we_q   <= 1'b0;
            stg_mis_q  <= 1'b0;
            stg_addr_q <= '0;
            stg_wd_q   <= 32'd0;
            if_valid_q <= 1'b0;
            d_valid_q  <= 1'b0;
            d_err_q    <= 1'b0;
            if_rdata_q <= 32'd0;
            d_rdata_q  <= 32'd0;
        end else begin
            cnt_q     <= cnt_d;
            stg_vld_q <= gnt_i || gnt_d;
            if (gnt_d) begin
                stg_own_q  <= 1'b1;
                stg_we_q   <= d_we;
                stg_mis_q  <= (d_addr[1:0] != 2'b00);
                stg_addr_q <= d_addr;
                stg_wd_q   <= d_wdata;
            end else if (gnt_i) begin
                // Fetches are word accesses: the low address bits are dropped.
                stg_own_q  <= 1'b0;
                stg_we_q   <= 1'b0;
                stg_mis_q  <= 1'b0;
                stg_addr_q <= {if_addr[AW-1:2], 2'b00};
            end

            if_valid_q <= stg_vld_q && !stg_own_q;
            d_valid_q  <= stg_vld_q && stg_own_q;
            d_err_q    <= stg_vld_q && stg_own_q && stg_mis_q;
            if (stg_vld_q && !stg_own_q) begin
                if_rdata_q <= mem_RD;
            end
            if (stg_vld_q && stg_own_q) begin
                d_rdata_q <= (stg_we_q || stg_mis_q) ? 32'd0 : mem_RD;
            end
        end
    end

    assign if_gnt   = gnt_i;
    assign d_gnt    = gnt_d;
    assign mem_A    = stg_addr_q;
    assign mem_WD   = stg_wd_q;
    // A store whose access cycle sees reset is dropped along with the rest of the pipe.
    assign mem_WE   = stg_vld_q && stg_own_q && stg_we_q && !stg_mis_q && !rst;
    assign if_valid = if_valid_q;
    assign if_rdata = if_rdata_q;
    assign d_valid  = d_valid_q;
    assign d_rdata  = d_rdata_q;
    assign d_err    = d_err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Purpose: directed + randomized check of mem_port_arbiter against a transaction-level model.
// Latency: model predicts grants per cycle and responses two cycles after each grant.
// Backpressure: bench requesters hold requests until the model predicts a grant.
module tb_mem_port_arbiter;

    localparam int MAX = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req, d_req, d_we;
    logic [31:0] if_addr, d_addr, d_wdata;
    logic        if_gnt, if_valid, d_gnt, d_valid, d_err, mem_WE;
    logic [31:0] if_rdata, d_rdata, mem_A, mem_WD, mem_RD;

    mem_port_arbiter #(.MAX_CONSEC(MAX), .AW(32)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_valid(if_valid), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_valid(d_valid), .d_rdata(d_rdata), .d_err(d_err),
        .mem_A(mem_A), .mem_WD(mem_WD), .mem_WE(mem_WE), .mem_RD(mem_RD)
    );

    always #5 clk = ~clk;

    // Memory attached to the DUT.
    logic [31:0] mem [256];
    assign mem_RD = mem[mem_A[9:2]];
    always @(posedge clk) if (mem_WE) mem[mem_A[9:2]] <= mem_WD;

    // Reference model: one transaction in access, one in response, plus its own memory image.
    logic [31:0] ref_mem [256];
    bit          m_acc_v, m_acc_own, m_acc_we;
    logic [31:0] m_acc_addr, m_acc_wd;
    bit          m_rsp_v, m_rsp_own, m_rsp_err;
    logic [31:0] m_rsp_dat;
    logic [31:0] m_ird, m_drd;
    int          m_cnt;
    bit          last_gi, last_gd;
    logic        obs_gi, obs_gd;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_flush();
        m_acc_v = 0; m_rsp_v = 0; m_ird = 0; m_drd = 0; m_cnt = 0;
        last_gi = 0; last_gd = 0;
    endtask

    // Called mid-cycle: compares every output against the model, then advances the model.
    task automatic check_cycle();
        bit e_gi, e_gd, e_iv, e_dv, e_de, e_we, mis;
        e_gi = 0; e_gd = 0;
        if (!rst) begin
            if (if_req && (!d_req || m_cnt == MAX)) e_gi = 1;
            else if (d_req)                           e_gd = 1;
        end
        e_iv = m_rsp_v && !m_rsp_own;
        e_dv = m_rsp_v && m_rsp_own;
        e_de = e_dv && m_rsp_err;
        if (e_iv) m_ird = m_rsp_dat;
        if (e_dv) m_drd = m_rsp_dat;
        e_we = !rst && m_acc_v && m_acc_own && m_acc_we && (m_acc_addr[1:0] == 2'b00);

        obs_gi = if_gnt; obs_gd = d_gnt;
        chk("if_gnt",   {31'd0, if_gnt},   {31'd0, e_gi});
        chk("d_gnt",    {31'd0, d_gnt},    {31'd0, e_gd});
        chk("if_valid", {31'd0, if_valid}, {31'd0, e_iv});
        chk("d_valid",  {31'd0, d_valid},  {31'd0, e_dv});
        chk("d_err",    {31'd0, d_err},    {31'd0, e_de});
        chk("mem_WE",   {31'd0, mem_WE},   {31'd0, e_we});
        chk("if_rdata", if_rdata, m_ird);
        chk("d_rdata",  d_rdata,  m_drd);
        if (m_acc_v) chk("mem_A", mem_A, m_acc_own ? m_acc_addr : (m_acc_addr & ~32'd3));
        if (e_we)    chk("mem_WD", mem_WD, m_acc_wd);

        if (rst) begin
            model_flush();
        end else begin
            m_rsp_v = m_acc_v;
            if (m_acc_v) begin
                mis       = m_acc_own && (m_acc_addr[1:0] != 2'b00);
                m_rsp_own = m_acc_own;
                m_rsp_err = mis;
                m_rsp_dat = (m_acc_own && (m_acc_we || mis)) ? 32'd0 : ref_mem[m_acc_addr[9:2]];
                if (e_we) ref_mem[m_acc_addr[9:2]] = m_acc_wd;
            end
            m_acc_v = e_gi || e_gd;
            if (e_gd) begin
                m_acc_own = 1; m_acc_we = d_we; m_acc_addr = d_addr; m_acc_wd = d_wdata;
            end else if (e_gi) begin
                m_acc_own = 0; m_acc_we = 0; m_acc_addr = if_addr;
            end
            if (e_gi || !if_req) m_cnt = 0;
            else if (e_gd)       m_cnt = m_cnt + 1;
            last_gi = e_gi; last_gd = e_gd;
        end
    endtask

    // One clock: check at the falling edge, then drop whichever request was granted.
    task automatic tick();
        @(negedge clk);
        check_cycle();
        @(posedge clk);
        #1;
        if (last_gi) if_req = 0;
        if (last_gd) d_req = 0;
    endtask

    initial begin
        logic [9:0]  pat;
        logic [31:0] old;
        rst = 1; if_req = 0; d_req = 0; d_we = 0;
        if_addr = 0; d_addr = 0; d_wdata = 0;
        for (int i = 0; i < 256; i++) begin
            mem[i] = $urandom; ref_mem[i] = mem[i];
        end
        mem[0] = 32'h0000_2403; ref_mem[0] = 32'h0000_2403;
        model_flush();
        repeat (2) @(posedge clk);
        #1;
        tick();                               // reset-state check
        rst = 0;
        tick();
        chk("rst_mem_A",  mem_A,  32'd0);
        chk("rst_mem_WD", mem_WD, 32'd0);

        // Fetch of word 0.
        if_req = 1; if_addr = 32'h0;
        tick();
        chk("t1_gnt", {31'd0, obs_gi}, 32'd1);
        repeat (3) tick();

        // Both requesting continuously: D,D,D,D,I,D,D,D,D,I.
        pat = 10'b01_1110_1111;
        for (int k = 0; k < 10; k++) begin
            if_req = 1; if_addr = 32'h8;
            d_req = 1; d_we = 0; d_addr = 32'h10;
            tick();
            chk("seq_d", {31'd0, obs_gd}, {31'd0, pat[k]});
            chk("seq_i", {31'd0, obs_gi}, {31'd0, ~pat[k]});
        end
        if_req = 0; d_req = 0;
        repeat (3) tick();

        // Store then immediate load of the same word.
        d_req = 1; d_we = 1; d_addr = 32'h40; d_wdata = 32'hDEAD_BEEF;
        tick();
        d_req = 1; d_we = 0; d_addr = 32'h40;
        repeat (4) tick();
        chk("raw_mem", mem[16], 32'hDEAD_BEEF);

        // Misaligned store must not touch memory.
        d_req = 1; d_we = 1; d_addr = 32'h42; d_wdata = 32'h1111_2222;
        repeat (4) tick();
        chk("mis_mem", mem[16], 32'hDEAD_BEEF);

        // Reset during the access cycle of a store.
        old = mem[17];
        d_req = 1; d_we = 1; d_addr = 32'h44; d_wdata = 32'h1234_5678;
        tick();
        rst = 1;
        tick();
        rst = 0;
        tick();
        chk("rst_wr_mem", mem[17], old);
        chk("rst_mem_A2", mem_A,   32'd0);

        // Fetch with low address bits set.
        if_req = 1; if_addr = 32'h7;
        repeat (4) tick();

        // Randomized traffic with occasional resets.
        for (int c = 0; c < 3000; c++) begin
            rst = ($urandom_range(0, 299) == 0);
            if (!if_req && $urandom_range(0, 2) == 0) begin
                if_req = 1; if_addr = $urandom_range(0, 1023);
            end
            if (!d_req && $urandom_range(0, 1) == 0) begin
                d_req = 1; d_we = $urandom_range(0, 1);
                d_addr = $urandom_range(0, 255) << 2;
                if ($urandom_range(0, 9) == 0) d_addr[1:0] = 2'($urandom_range(1, 3));
                d_wdata = $urandom;
            end
            tick();
        end
        rst = 0; if_req = 0; d_req = 0;
        repeat (3) tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
        $finish;
    end

endmodule
